// File: rtl/replay_receiver_pkg.sv
// Shared types and sizing for the link replay receiver.
// Holds the link sizing constants, the receiver FSM state type and the
// payload structs that connect this block field-for-field to its peers.
package replay_receiver_pkg;

    localparam int unsigned BUFFER_SIZE   = 16;
    localparam int unsigned PACKET_WIDTH  = 64;
    localparam int unsigned SW            = $clog2(BUFFER_SIZE);
    localparam int unsigned ACK_THRESHOLD = 4;
    localparam int unsigned ACK_TIMEOUT   = 8;
    localparam int unsigned NACK_TIMEOUT  = 32;
    localparam int unsigned IDLE_W        = $clog2(ACK_TIMEOUT) + 1;
    localparam int unsigned NACK_W        = $clog2(NACK_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        NACK_PEND = 2'd1,
        DISCARD   = 2'd2
    } replay_rx_state_e;

    // Ack side of the replay buffer input, bit-compatible with the transmitter.
    typedef struct packed {
        logic          ack;
        logic [SW-1:0] ack_count;
        logic          nack;
    } replay_ack_out_t;

    typedef struct packed {
        logic                    valid;
        logic [SW-1:0]           seq;
        logic                    crc_ok;
        logic [PACKET_WIDTH-1:0] packet;
    } replay_rx_in_t;

    // Sequence numbers wrap naturally at BUFFER_SIZE.
    function automatic logic [SW-1:0] seq_inc(input logic [SW-1:0] s);
        return s + SW'(1);
    endfunction

endpackage

// File: rtl/replay_receiver_if.sv
// Link-side and consumer-side bundle of the replay receiver.
//   rx_*      : deframed packet from the PHY (no backpressure)
//   out_*     : one-entry output register toward the mesh router
//   ack/nack  : credit return toward the peer replay buffer
interface replay_receiver_if;
    import replay_receiver_pkg::*;

    logic                    rx_valid;
    logic [SW-1:0]           rx_seq;
    logic                    rx_crc_ok;
    logic [PACKET_WIDTH-1:0] rx_packet;
    logic                    out_valid;
    logic [PACKET_WIDTH-1:0] out_packet;
    logic                    out_ready;
    logic                    ack;
    logic [SW-1:0]           ack_count;
    logic                    nack;

    modport slave (
        input  rx_valid, rx_seq, rx_crc_ok, rx_packet, out_ready,
        output out_valid, out_packet, ack, ack_count, nack
    );

    modport master (
        output rx_valid, rx_seq, rx_crc_ok, rx_packet, out_ready,
        input  out_valid, out_packet, ack, ack_count, nack
    );
endinterface

// File: rtl/replay_receiver_ack_coalescer.sv
// Ack coalescer: counts accepted packets and returns them to the peer as one
// ack pulse on reaching the threshold, after an idle timeout, or on a forced
// flush (error path).
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   i_accept      : a packet was accepted this cycle
//   i_flush       : return all pending credit now (never with i_accept)
//   o_ack         : registered single-cycle ack pulse
//   o_ack_count   : credit returned by the pulse, 0 otherwise
module replay_receiver_ack_coalescer
    import replay_receiver_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_accept,
    input  logic          i_flush,
    output logic          o_ack,
    output logic [SW-1:0] o_ack_count
);

    logic [SW-1:0]     r_pend_cnt;
    logic [IDLE_W-1:0] r_idle_timer;
    logic              r_ack;
    logic [SW-1:0]     r_ack_count;

    logic [SW-1:0]     w_pend_next;
    logic [IDLE_W-1:0] w_idle_next;
    logic              w_ack_next;
    logic [SW-1:0]     w_ack_count_next;

    // Next credit state; flush wins, then threshold, then idle timeout.
    always_comb begin
        w_pend_next      = r_pend_cnt;
        w_idle_next      = r_idle_timer;
        w_ack_next       = 1'b0;
        w_ack_count_next = '0;
        if (i_flush) begin
            w_pend_next = '0;
            w_idle_next = '0;
            if (r_pend_cnt != '0) begin
                w_ack_next       = 1'b1;
                w_ack_count_next = r_pend_cnt;
            end
        end else if (i_accept) begin
            w_idle_next = '0;
            if (r_pend_cnt == SW'(ACK_THRESHOLD - 1)) begin
                w_pend_next      = '0;
                w_ack_next       = 1'b1;
                w_ack_count_next = SW'(ACK_THRESHOLD);
            end else begin
                w_pend_next = r_pend_cnt + SW'(1);
            end
        end else if (r_pend_cnt != '0) begin
            if (r_idle_timer == IDLE_W'(ACK_TIMEOUT - 1)) begin
                w_pend_next      = '0;
                w_idle_next      = '0;
                w_ack_next       = 1'b1;
                w_ack_count_next = r_pend_cnt;
            end else begin
                w_idle_next = r_idle_timer + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_cnt   <= '0;
            r_idle_timer <= '0;
            r_ack        <= 1'b0;
            r_ack_count  <= '0;
        end else begin
            r_pend_cnt   <= w_pend_next;
            r_idle_timer <= w_idle_next;
            r_ack        <= w_ack_next;
            r_ack_count  <= w_ack_count_next;
        end
    end

    assign o_ack       = r_ack;
    assign o_ack_count = r_ack_count;

endmodule

// File: rtl/replay_receiver.sv
// Replay receiver: checks sequence and CRC of link packets, delivers in-order
// good packets through a one-entry output register, and returns coalesced
// acks and nacks to the peer replay buffer.
// Ports:
//   clk     : clock
//   nreset  : async active-low reset (deassertion synchronised internally)
//   link    : replay_receiver_if.slave (rx_*, out_*, ack, ack_count, nack)
module replay_receiver
    import replay_receiver_pkg::*;
(
    input  logic               clk,
    input  logic               nreset,
    replay_receiver_if.slave   link
);

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;

    replay_rx_in_t           w_rx;
    replay_ack_out_t         w_ack_out;

    replay_rx_state_e        r_state;
    replay_rx_state_e        w_state_next;
    logic [SW-1:0]           r_exp_seq;
    logic [NACK_W-1:0]       r_nack_timer;
    logic [NACK_W-1:0]       w_nack_timer_next;
    logic                    r_nack;
    logic                    w_nack_next;
    logic                    r_out_valid;
    logic [PACKET_WIDTH-1:0] r_out_packet;

    logic                    w_space;
    logic                    w_match;
    logic                    w_accept;
    logic                    w_flush;
    logic                    w_ack;
    logic [SW-1:0]           w_ack_count;

    // Async assert, synchronous release of the internal reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_rx = {link.rx_valid, link.rx_seq, link.rx_crc_ok, link.rx_packet};

    // A packet is only good if the output register can take it this cycle.
    assign w_space  = !r_out_valid || link.out_ready;
    assign w_match  = w_rx.valid && w_rx.crc_ok && (w_rx.seq == r_exp_seq) && w_space;
    assign w_accept = w_match && (r_state != NACK_PEND);
    assign w_flush  = (r_state == RUN) && w_rx.valid && !w_match;

    // Next state and nack retry timer.
    always_comb begin
        w_state_next      = r_state;
        w_nack_timer_next = r_nack_timer;
        w_nack_next       = 1'b0;
        case (r_state)
            RUN: begin
                if (w_flush) begin
                    w_state_next = NACK_PEND;
                end
            end
            NACK_PEND: begin
                w_state_next      = DISCARD;
                w_nack_next       = 1'b1;
                w_nack_timer_next = '0;
            end
            DISCARD: begin
                if (w_accept) begin
                    w_state_next      = RUN;
                    w_nack_timer_next = '0;
                end else if (r_nack_timer == NACK_W'(NACK_TIMEOUT - 1)) begin
                    w_nack_next       = 1'b1;
                    w_nack_timer_next = '0;
                end else begin
                    w_nack_timer_next = r_nack_timer + NACK_W'(1);
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= RUN;
            r_nack_timer <= '0;
            r_nack       <= 1'b0;
            r_exp_seq    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_nack_timer <= w_nack_timer_next;
            r_nack       <= w_nack_next;
            if (w_accept) begin
                r_exp_seq <= seq_inc(r_exp_seq);
            end
        end
    end

    // One-entry output register; load and drain may coincide.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_packet <= w_rx.packet;
        end else if (link.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    replay_receiver_ack_coalescer u_ack_coalescer (
        .clk         (clk),
        .rst_n       (w_rst_n),
        .i_accept    (w_accept),
        .i_flush     (w_flush),
        .o_ack       (w_ack),
        .o_ack_count (w_ack_count)
    );

    assign w_ack_out = {w_ack, w_ack_count, r_nack};

    assign link.out_valid  = r_out_valid;
    assign link.out_packet = r_out_packet;
    assign link.ack        = w_ack_out.ack;
    assign link.ack_count  = w_ack_out.ack_count;
    assign link.nack       = w_ack_out.nack;

endmodule
